lrf_frame_sequencer: RTL and testbench
======================================

# lrf_frame_sequencer

Control sequencer for the lucky-region-fusion (LRF) datapath. It accepts the input AXI-Stream handshake and counts beats and frames. It issues read addresses to the average-frame and fused-frame LSUs, and carries per-beat control through a fixed-latency tag pipeline that matches the HSSIM/fusion datapath. It also generates write-back enables and the output stream's valid/last. The block carries no pixel data; it sits beside the datapath and sequences it.

## Interface
- PIXELS_PER_BEAT, 16, pixels per stream beat
- IMAGE_DIM, 512, frame is IMAGE_DIM×IMAGE_DIM pixels
- FUSE_COUNT, 16, frames per fusion window; power of 2, ≥2
- PIPE_DELAY, 10, datapath latency in enabled cycles; ≥1
- BEATS (local) = IMAGE_DIM²/PIXELS_PER_BEAT; AW (local) = $clog2(BEATS); FW (local) = $clog2(FUSE_COUNT)

Ports:
- s_axis_aclk  in  1  sole clock, rising edge
- s_axis_areset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, leaves IDLE
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  input end-of-frame marker
- s_axis_tready  out  1  input ready
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  fused beat valid
- m_axis_tlast  out  1  last beat of fused frame
- rd_en  out  1  LSU read strobe (avg + fused), equals step
- rd_addr  out  AW  beat index of accepted beat
- frame_first  out  1  accepted beat belongs to frame 0 since start
- warmup  out  1  accepted beat belongs to frames 0..FUSE_COUNT-1 since start
- wr_en  out  1  LSU write-back strobe
- wr_addr  out  AW  write-back beat index
- wr_init  out  1  write-back beat is from frame 0 (initialise avg as FUSE_COUNT·f0)
- frame_idx  out  FW  current input frame index modulo FUSE_COUNT
- busy  out  1  state≠IDLE or tag pipeline non-empty
- err_tlast  out  1  sticky framing error, cleared by reset or start

## Operation
- States: IDLE, WARMUP, STEADY.
  - IDLE→WARMUP on start.
  - WARMUP→STEADY when the last beat of frame FUSE_COUNT-1 is accepted.
  - STEADY persists until reset.
  - start outside IDLE is ignored.
- ce = ~(m_axis_tvalid & ~m_axis_tready) is the global enable for the tag pipeline.
- s_axis_tready = ce & (state≠IDLE). step = s_axis_tvalid & s_axis_tready.
- On step:
  - rd_en=1 and rd_addr=beat_cnt (combinational). frame_first and warmup are also combinational.
  - beat_cnt increments. At BEATS-1 it wraps to 0 and frame_idx increments mod FUSE_COUNT.
  - frames_seen (saturating at FUSE_COUNT) increments on wrap.
- Tag pipeline, PIPE_DELAY stages, shifts only when ce.
  - Stage-0 fields: {valid=step, addr=beat_cnt, emit=(frame_idx==FUSE_COUNT-1), last=(beat_cnt==BEATS-1), init=frame_first}.
  - A non-step cycle with ce inserts a bubble.
- Head stage outputs:
  - wr_en = head.valid & ce; wr_addr = head.addr; wr_init = head.init & head.valid.
  - m_axis_tvalid = head.valid & head.emit; m_axis_tlast = m_axis_tvalid & head.last.
- Framing check:
  - tlast on step with beat_cnt≠BEATS-1: set err_tlast, force frame end (beat_cnt→0, frame advance); stage-0 last=1.
  - No tlast with beat_cnt==BEATS-1: set err_tlast, wrap normally.
- Reset mid-operation: all counters, state and pipeline valid bits clear next edge. In-flight beats are dropped and no wr_en is issued for them.

## Timing
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, wr_en=0, wr_addr=0, wr_init=0.
  - rd_en=0, rd_addr=0, frame_first=0, warmup=0, frame_idx=0, busy=0, err_tlast=0.
- Read: rd_en/rd_addr are in the same cycle as step.
- Write-back: beat accepted at cycle t appears at the head after PIPE_DELAY ce-high cycles. With no stalls, wr_en is at t+PIPE_DELAY.
- Output stall:
  - While m_axis_tvalid & ~m_axis_tready: pipeline frozen, s_axis_tready=0, wr_en=0.
  - The head beat's wr_en fires in the cycle its output handshake completes.
- Non-emit frames ignore m_axis_tready (m_axis_tvalid=0 ⇒ ce=1).
- start and step are never in the same cycle (s_axis_tready=0 in IDLE); the first acceptance is no earlier than start+1.
- Simultaneous reset and start: reset wins.

## Test plan
- Params: IMAGE_DIM=8, PIXELS_PER_BEAT=16 (BEATS=4), FUSE_COUNT=4, PIPE_DELAY=3.
- Reset, start, stream 4 frames (16 beats) continuously, m_axis_tready=1:
  - rd_addr 0,1,2,3 repeating; frame_first high for beats 0-3 only; warmup high for all 16.
  - wr_init on the first 4 wr_en; m_axis_tvalid for beats 12-15 at cycles +3; m_axis_tlast on the 16th; state STEADY after.
- Hold m_axis_tready=0 for 5 cycles while the first emitted beat is at the head:
  - s_axis_tready=0 and wr_en=0 throughout; the same head beat (wr_addr=0) is held.
  - On release, exactly one wr_en per beat and no loss or duplication.
- s_axis_tlast asserted on beat 1 of frame 1:
  - err_tlast=1 next cycle; the next beat has rd_addr=0, frame_idx=2; stage last=1 for that beat.
- Omit tlast on beat 3: err_tlast=1, rd_addr wraps to 0, frame_idx increments.
- Assert reset with 2 beats in flight: the next cycle has wr_en=0, m_axis_tvalid=0, busy=0, frame_idx=0, state IDLE.
- Toggle s_axis_tvalid 1-0-1-0 in frame 0: wr_en pulses mirror the pattern exactly 3 cycles later.

Source files
------------

// File: rtl/lrf_frame_sequencer.sv
// Control sequencer beside the LRF datapath: counts beats/frames, strobes LSU reads,
// and carries per-beat tags through a PIPE_DELAY-deep pipeline to drive write-back and output.
module lrf_frame_sequencer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int FUSE_COUNT      = 16,
  parameter int PIPE_DELAY      = 10,
  localparam int BEATS = (IMAGE_DIM * IMAGE_DIM) / PIXELS_PER_BEAT,
  localparam int AW    = $clog2(BEATS),
  localparam int FW    = $clog2(FUSE_COUNT)
) (
  input  logic          s_axis_aclk,
  input  logic          s_axis_areset,
  input  logic          start,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  input  logic          m_axis_tready,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          frame_first,
  output logic          warmup,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_init,
  output logic [FW-1:0] frame_idx,
  output logic          busy,
  output logic          err_tlast
);

  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  localparam logic [FW-1:0] EMIT_IDX  = FW'(FUSE_COUNT - 1);
  localparam logic [FW:0]   FULL      = (FW + 1)'(FUSE_COUNT);
  localparam logic [FW:0]   LAST_WARM = (FW + 1)'(FUSE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, STEADY} state_t;

  state_t          state;
  logic [AW-1:0]   beat_cnt;
  logic [FW:0]     frames_seen;
  logic            ce;
  logic            step;
  logic            beat_end;
  logic            frame_end;

  logic [PIPE_DELAY-1:0] vld_p;
  logic [PIPE_DELAY-1:0] emit_p;
  logic [PIPE_DELAY-1:0] last_p;
  logic [PIPE_DELAY-1:0] init_p;
  logic [AW-1:0]         addr_p [PIPE_DELAY];

  assign m_axis_tvalid = vld_p[PIPE_DELAY-1] & emit_p[PIPE_DELAY-1];
  assign m_axis_tlast  = m_axis_tvalid & last_p[PIPE_DELAY-1];
  assign ce            = ~(m_axis_tvalid & ~m_axis_tready);
  assign s_axis_tready = ce & (state != IDLE);
  assign step          = s_axis_tvalid & s_axis_tready;
  assign beat_end      = (beat_cnt == LAST_BEAT);
  // An early tlast closes the frame just like the natural last beat does.
  assign frame_end     = step & (s_axis_tlast | beat_end);

  assign rd_en       = step;
  assign rd_addr     = beat_cnt;
  assign frame_first = step & (frames_seen == '0);
  assign warmup      = step & (frames_seen < FULL);

  assign wr_en   = vld_p[PIPE_DELAY-1] & ce;
  assign wr_addr = vld_p[PIPE_DELAY-1] ? addr_p[PIPE_DELAY-1] : '0;
  assign wr_init = vld_p[PIPE_DELAY-1] & init_p[PIPE_DELAY-1];
  assign busy    = (state != IDLE) | (|vld_p);

  // Control: state, counters, error flag and tag valid bits
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      frame_idx   <= '0;
      frames_seen <= '0;
      err_tlast   <= 1'b0;
      vld_p       <= '0;
    end else begin
      if (state == IDLE && start) begin
        state     <= WARMUP;
        err_tlast <= 1'b0;
      end
      if (step) begin
        if (s_axis_tlast != beat_end) err_tlast <= 1'b1;
        if (frame_end) begin
          beat_cnt  <= '0;
          frame_idx <= frame_idx + FW'(1);
          if (frames_seen != FULL) frames_seen <= frames_seen + (FW + 1)'(1);
          if (state == WARMUP && frames_seen == LAST_WARM) state <= STEADY;
        end else begin
          beat_cnt <= beat_cnt + AW'(1);
        end
      end
      if (ce) begin
        vld_p[0] <= step;
        for (int k = 1; k < PIPE_DELAY; k++) vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Tag payload: shifts with the valid bits, qualified by them at the head
  always_ff @(posedge s_axis_aclk) begin
    if (ce) begin
      addr_p[0] <= beat_cnt;
      emit_p[0] <= (frame_idx == EMIT_IDX);
      last_p[0] <= s_axis_tlast | beat_end;
      init_p[0] <= frame_first;
      for (int k = 1; k < PIPE_DELAY; k++) begin
        addr_p[k] <= addr_p[k-1];
        emit_p[k] <= emit_p[k-1];
        last_p[k] <= last_p[k-1];
        init_p[k] <= init_p[k-1];
      end
    end
  end

endmodule

// File: tb/tb_lrf_frame_sequencer.sv
// Bench for lrf_frame_sequencer: directed phases plus random traffic, every cycle
// compared against a beat-record model that ages accepted beats in enabled cycles.
module tb_lrf_frame_sequencer;

  localparam int PPB   = 16;
  localparam int DIM   = 8;
  localparam int FC    = 4;
  localparam int PD    = 3;
  localparam int BEATS = DIM * DIM / PPB;

  logic       clk = 1'b0;
  logic       rst, start, s_axis_tvalid, s_axis_tlast, m_axis_tready;
  logic       s_axis_tready, m_axis_tvalid, m_axis_tlast, rd_en, frame_first, warmup;
  logic       wr_en, wr_init, busy, err_tlast;
  logic [1:0] rd_addr, wr_addr, frame_idx;

  int n_checks = 0;
  int n_errors = 0;

  lrf_frame_sequencer #(
    .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .FUSE_COUNT(FC), .PIPE_DELAY(PD)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst), .start(start),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .rd_en(rd_en), .rd_addr(rd_addr), .frame_first(frame_first), .warmup(warmup),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_init(wr_init), .frame_idx(frame_idx),
    .busy(busy), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  // Reference model: accepted beats with their enabled-cycle age since acceptance
  typedef struct {int addr; bit emit; bit last; bit init; int age;} beat_t;
  beat_t fly[$];
  bit    m_started = 0;
  bit    m_err     = 0;
  int    m_beat    = 0;
  int    m_frames  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit head_valid();
    return fly.size() > 0 && fly[0].age == PD;
  endfunction

  function automatic bit head_emit();
    return head_valid() && fly[0].emit;
  endfunction

  task automatic run_cycle(input bit sv, input bit tl, input bit mr, input bit st,
                           input bit rs, input bit cmp);
    bit hv, e_mv, e_ce, e_tr, e_step;
    beat_t nb;
    @(negedge clk);
    s_axis_tvalid = sv; s_axis_tlast = tl; m_axis_tready = mr; start = st; rst = rs;
    hv     = head_valid();
    e_mv   = head_emit();
    e_ce   = !(e_mv && !mr);
    e_tr   = e_ce && m_started;
    e_step = sv && e_tr;
    #1;
    if (cmp) begin
      check_val("s_axis_tready", s_axis_tready, e_tr);
      check_val("m_axis_tvalid", m_axis_tvalid, e_mv);
      check_val("m_axis_tlast",  m_axis_tlast,  e_mv && fly[0].last);
      check_val("rd_en",         rd_en,         e_step);
      check_val("rd_addr",       rd_addr,       m_beat);
      check_val("frame_first",   frame_first,   e_step && m_frames == 0);
      check_val("warmup",        warmup,        e_step && m_frames < FC);
      check_val("wr_en",         wr_en,         hv && e_ce);
      check_val("wr_addr",       wr_addr,       hv ? fly[0].addr : 0);
      check_val("wr_init",       wr_init,       hv && fly[0].init);
      check_val("frame_idx",     frame_idx,     m_frames % FC);
      check_val("busy",          busy,          m_started || fly.size() > 0);
      check_val("err_tlast",     err_tlast,     m_err);
    end
    @(posedge clk);
    if (rs) begin
      fly.delete();
      m_started = 0; m_err = 0; m_beat = 0; m_frames = 0;
    end else begin
      if (e_ce) begin
        foreach (fly[i]) fly[i].age++;
        if (fly.size() > 0 && fly[0].age > PD) void'(fly.pop_front());
      end
      if (e_step) begin
        nb.addr = m_beat;
        nb.emit = (m_frames % FC) == FC - 1;
        nb.last = tl || m_beat == BEATS - 1;
        nb.init = m_frames == 0;
        nb.age  = 1;
        fly.push_back(nb);
        if (tl != (m_beat == BEATS - 1)) m_err = 1;
        if (nb.last) begin
          m_beat = 0;
          m_frames++;
        end else begin
          m_beat++;
        end
      end
      if (st && !m_started) begin
        m_started = 1;
        m_err     = 0;
      end
    end
  endtask

  initial begin
    bit mr_v;
    int hold;
    rst = 1; start = 0; s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 1;
    run_cycle(0, 0, 1, 0, 1, 0);
    run_cycle(0, 0, 1, 1, 1, 1);
    run_cycle(0, 0, 1, 0, 0, 1);
    run_cycle(1, 0, 0, 0, 0, 1);

    // Four frames back to back through warmup
    run_cycle(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 16; i++) run_cycle(1, m_beat == BEATS - 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 1, 0, 0, 1);

    // Next emitting frame with a five-cycle downstream stall at the head
    hold = 0;
    for (int i = 0; i < 32; i++) begin
      mr_v = 1;
      if (head_emit() && hold < 5) begin
        mr_v = 0;
        hold++;
      end
      run_cycle(1, m_beat == BEATS - 1, mr_v, 0, 0, 1);
    end
    for (int i = 0; i < 8 && m_beat != 0; i++) run_cycle(1, m_beat == BEATS - 1, 1, 0, 0, 1);

    // Early tlast on beat 1, then a frame whose beat 3 lacks tlast
    run_cycle(1, 0, 1, 0, 0, 1);
    run_cycle(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) run_cycle(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) run_cycle(1, m_beat == BEATS - 1, 1, 0, 0, 1);

    // Reset with two beats in flight
    run_cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 1, 0, 0, 1);
    run_cycle(1, 0, 1, 0, 0, 1);
    run_cycle(1, 0, 1, 0, 0, 1);
    run_cycle(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 1, 0, 0, 1);

    // Alternating tvalid in frame 0
    run_cycle(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 8; i++) run_cycle(i % 2 == 0, m_beat == BEATS - 1 && i % 2 == 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 1, 0, 0, 1);

    // Random traffic with occasional framing errors, stray starts and one reset
    for (int i = 0; i < 700; i++) begin
      run_cycle($urandom_range(0, 3) != 0,
                (m_beat == BEATS - 1) ^ ($urandom_range(0, 19) == 0),
                $urandom_range(0, 3) != 0,
                i == 352 || $urandom_range(0, 49) == 0,
                i == 350, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
